// File: rtl/fetch_sequencer.sv
// PC/fetch control ahead of a combinational ROM: pre-scans a program for label markers, then runs it.
// Optional FETCH_DUP_LABEL_CHECK_EN flags duplicate label markers found during the scan.
module fetch_sequencer #(
  parameter logic [7:0] PROG0_BASE = 8'h00,
  parameter logic [7:0] PROG1_BASE = 8'h40,
  parameter int         NUM_LABELS = 16,
  parameter logic [7:0] HALT_OP    = 8'hE0,
  parameter logic [7:0] ILLEGAL_OP = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       prog_sel_i,
  input  logic [7:0] instruction_i,
  input  logic       stall_i,
  input  logic       branch_i,
  input  logic [3:0] branch_label_i,
  output logic [7:0] address_o,
  output logic [7:0] instr_o,
  output logic       instr_valid_o,
  output logic       busy_o,
  output logic       halted_o,
  output logic       err_o
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RUN, S_HALTED} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              pc_q, pc_d;
  logic [7:0]              base_q, base_d;
  logic                    err_q, err_d;
  logic [NUM_LABELS-1:0]   lbl_vld_q, lbl_vld_d;
  logic [7:0]              lbl_tab_q [NUM_LABELS];
  logic                    tab_we;
  logic [3:0]              tab_idx;

  logic is_marker, is_term;
  assign is_marker = (instruction_i[7:4] == 4'hF) && (instruction_i != ILLEGAL_OP);
  assign is_term   = (instruction_i == HALT_OP) || (instruction_i == ILLEGAL_OP);
  assign tab_idx   = instruction_i[3:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    base_d    = base_q;
    err_d     = err_q;
    lbl_vld_d = lbl_vld_q;
    tab_we    = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) begin
          state_d   = S_SCAN;
          base_d    = prog_sel_i ? PROG1_BASE : PROG0_BASE;
          pc_d      = prog_sel_i ? PROG1_BASE : PROG0_BASE;
          lbl_vld_d = '0;
          err_d     = 1'b0;
        end
      end
      S_SCAN: begin
        if (is_marker) begin
`ifdef FETCH_DUP_LABEL_CHECK_EN
          // First definition of a label is kept; a repeat only raises the error.
          if (lbl_vld_q[tab_idx]) begin
            err_d = 1'b1;
          end else begin
            tab_we             = 1'b1;
            lbl_vld_d[tab_idx] = 1'b1;
          end
`else
          tab_we             = 1'b1;
          lbl_vld_d[tab_idx] = 1'b1;
`endif
        end
        if (is_term || pc_q == 8'hFF) begin
          state_d = S_RUN;
          pc_d    = base_q;
          if (!is_term) err_d = 1'b1;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      S_RUN: begin
        if (stall_i) begin
          pc_d = pc_q;
        end else if (branch_i) begin
          if (lbl_vld_q[branch_label_i]) begin
            pc_d = lbl_tab_q[branch_label_i];
          end else begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end
        end else if (instruction_i == HALT_OP) begin
          state_d = S_HALTED;
        end else if (instruction_i == ILLEGAL_OP) begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'h00;
      base_q    <= PROG0_BASE;
      err_q     <= 1'b0;
      lbl_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      base_q    <= base_d;
      err_q     <= err_d;
      lbl_vld_q <= lbl_vld_d;
    end
  end

  // Table contents need no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (tab_we) lbl_tab_q[tab_idx] <= pc_q;
  end

  assign address_o     = pc_q;
  assign instr_o       = instruction_i;
  assign instr_valid_o = (state_q == S_RUN) && !stall_i;
  assign busy_o        = (state_q == S_SCAN) || (state_q == S_RUN);
  assign halted_o      = (state_q == S_HALTED);
  assign err_o         = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a bench-owned ROM model; vector table for RUN-phase sequencing.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       prog_sel_i = 1'b0;
  logic [7:0] instruction_i;
  logic       stall_i = 1'b0;
  logic       branch_i = 1'b0;
  logic [3:0] branch_label_i = 4'd0;
  logic [7:0] address_o;
  logic [7:0] instr_o;
  logic       instr_valid_o;
  logic       busy_o;
  logic       halted_o;
  logic       err_o;

  logic [7:0] rom [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instruction_i = rom[address_o];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
    .instruction_i(instruction_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_label_i(branch_label_i), .address_o(address_o), .instr_o(instr_o),
    .instr_valid_o(instr_valid_o), .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o)
  );

  typedef struct {
    logic       start;
    logic       stall;
    logic       branch;
    logic [3:0] label;
    logic [7:0] e_addr;
    logic       e_vld;
    logic       e_halt;
    logic       e_err;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic sel);
    start_i = 1'b1;
    prog_sel_i = sel;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_run(input string name, input int exp_n);
    int n;
    n = 0;
    while (!instr_valid_o && n < 400) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    logic [3:0] lbls [4];
    logic [7:0] dests [4];
    logic [7:0] dup_exp_addr;
    logic       dup_exp_err;

    // Program 0 at 00..3F, program 1 at 40..8A, rest is the ROM default.
    for (int a = 0; a < 256; a++) rom[a] = 8'hFF;
    for (int a = 1; a < 8'h3F; a++) rom[a] = 8'h01;
    rom[8'h00] = 8'hC0; rom[8'h0B] = 8'hF0; rom[8'h20] = 8'hF5; rom[8'h33] = 8'hF7;
    rom[8'h34] = 8'hA0; rom[8'h3E] = 8'hF8; rom[8'h3F] = 8'hE0;
    for (int a = 8'h41; a < 8'h8A; a++) rom[a] = 8'h02;
    rom[8'h40] = 8'hC0; rom[8'h4B] = 8'hF0; rom[8'h52] = 8'hF1; rom[8'h5F] = 8'hF2;
    rom[8'h7F] = 8'hF6; rom[8'h8A] = 8'hE0;

    //        start stall br  label  addr   vld halt err
    vec[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 4'd5, 8'h01, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 4'd0, 8'h20, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 4'd0, 8'h20, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 4'd0, 8'h20, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 4'd0, 8'h20, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h0B, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 4'd7, 8'h0C, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h33, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 8'h34, 1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b1, 4'd9, 8'h0B, 1'b1, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h0B, 1'b0, 1'b1, 1'b1};
    vec[12] = '{1'b0, 1'b0, 1'b1, 4'd0, 8'h0B, 1'b0, 1'b1, 1'b1};

    // Reset values
    tick(); tick();
    chk("rst_addr", address_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_valid", instr_valid_o, 1'b0);
    reset = 1'b0;
    tick();

    // Reset mid-scan acts immediately
    do_start(1'b1);
    repeat (16) tick();
    chk("midscan_addr", address_o, 8'h50);
    chk("midscan_busy", busy_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr", address_o, 8'h00);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_err", err_o, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Program 1 scan and label table
    do_start(1'b1);
    chk("scan1_addr", address_o, 8'h40);
    chk("scan1_busy", busy_o, 1'b1);
    chk("scan1_valid", instr_valid_o, 1'b0);
    wait_run("scan1_cycles", 75);
    chk("run1_addr", address_o, 8'h40);
    chk("run1_instr", instr_o, 8'hC0);
    chk("run1_err", err_o, 1'b0);
    lbls  = '{4'd0, 4'd1, 4'd2, 4'd6};
    dests = '{8'h4B, 8'h52, 8'h5F, 8'h7F};
    branch_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      branch_label_i = lbls[i];
      tick();
      chk("label1_dest", address_o, dests[i]);
      chk("label1_valid", instr_valid_o, 1'b1);
    end
    branch_label_i = 4'd3;
    tick();
    branch_i = 1'b0;
    chk("badlbl_halted", halted_o, 1'b1);
    chk("badlbl_err", err_o, 1'b1);
    chk("badlbl_addr", address_o, 8'h7F);

    // Restart clears err; program 0 then driven from the vector table
    do_start(1'b0);
    chk("restart_err", err_o, 1'b0);
    chk("restart_busy", busy_o, 1'b1);
    chk("restart_addr", address_o, 8'h00);
    wait_run("scan0_cycles", 64);
    for (int i = 0; i < 13; i++) begin
      start_i = vec[i].start;
      stall_i = vec[i].stall;
      branch_i = vec[i].branch;
      branch_label_i = vec[i].label;
      #1;
      chk("vec_addr", address_o, vec[i].e_addr);
      chk("vec_valid", instr_valid_o, vec[i].e_vld);
      chk("vec_halted", halted_o, vec[i].e_halt);
      chk("vec_err", err_o, vec[i].e_err);
      tick();
    end
    start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0;
    chk("frozen_addr", address_o, 8'h0B);

    // Halt presented once, stall holds it
    do_start(1'b0);
    wait_run("scan0b_cycles", 64);
    branch_i = 1'b1; branch_label_i = 4'd8;
    tick();
    branch_i = 1'b0;
    chk("lbl8_addr", address_o, 8'h3E);
    tick();
    stall_i = 1'b1;
    #1;
    chk("halt_stall_valid", instr_valid_o, 1'b0);
    chk("halt_stall_halted", halted_o, 1'b0);
    tick();
    stall_i = 1'b0;
    #1;
    chk("halt_addr", address_o, 8'h3F);
    chk("halt_instr", instr_o, 8'hE0);
    chk("halt_valid", instr_valid_o, 1'b1);
    tick();
    chk("halted", halted_o, 1'b1);
    chk("halted_valid", instr_valid_o, 1'b0);
    chk("halted_busy", busy_o, 1'b0);
    chk("halted_err", err_o, 1'b0);

    // Scan with no terminator wraps at FF
    for (int a = 8'h40; a < 256; a++) rom[a] = 8'h01;
    do_start(1'b1);
    wait_run("wrap_cycles", 192);
    chk("wrap_err", err_o, 1'b1);
    chk("wrap_addr", address_o, 8'h40);

    // Duplicate label markers
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8'h10; a++) rom[a] = 8'h01;
    rom[8'h05] = 8'hF3; rom[8'h09] = 8'hF3; rom[8'h10] = 8'hE0;
`ifdef FETCH_DUP_LABEL_CHECK_EN
    dup_exp_err = 1'b1; dup_exp_addr = 8'h05;
`else
    dup_exp_err = 1'b0; dup_exp_addr = 8'h09;
`endif
    do_start(1'b0);
    wait_run("dup_cycles", 17);
    chk("dup_err", err_o, dup_exp_err);
    branch_i = 1'b1; branch_label_i = 4'd3;
    tick();
    branch_i = 1'b0;
    chk("dup_label3", address_o, dup_exp_addr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch control stage that sits directly upstream of the combinational instruction ROM (inst_rom). It drives the ROM address and passes the returned instruction to decode/execute.
- On start, it pre-scans the selected program for label markers (1111_nnnn) and builds a label-to-address table.
- It then runs the program sequentially, resolving jmp/beq0 label indices from that table, until it fetches halt.

Parameters:
- PROG0_BASE, 8'h00, start address of program select 0.
- PROG1_BASE, 8'h40, start address of program select 1.
- NUM_LABELS, 16, label table depth; the label index is the low 4 bits of marker and branch opcodes.
- HALT_OP, 8'hE0, halt opcode.
- ILLEGAL_OP, 8'hFF, ROM default word; treated as an implicit end of program.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start_i, input, 1, one-cycle pulse; begins scan of the selected program. Honoured only in IDLE or HALTED.
- prog_sel_i, input, 1, 0 selects PROG0_BASE, 1 selects PROG1_BASE; sampled with start_i.
- instruction_i, input, 8, ROM data; combinational function of address_o.
- stall_i, input, 1, holds the PC in RUN.
- branch_i, input, 1, execute requests a taken jmp/beq0 for the current instruction.
- branch_label_i, input, 4, label index of the taken branch.
- address_o, output, 8, ROM address (equals PC).
- instr_o, output, 8, instruction forwarded to decode.
- instr_valid_o, output, 1, instr_o is a valid RUN-phase instruction.
- busy_o, output, 1, high in SCAN or RUN.
- halted_o, output, 1, high in HALTED.
- err_o, output, 1, sticky error flag; cleared by start_i or reset.

Behaviour:
- One clock domain. Reset is asynchronous and active-high: clk and reset, reset acts immediately, with no synchronous clear.
- Reset values:
  - state IDLE, PC 0, address_o 0.
  - instr_valid_o 0, busy_o 0, halted_o 0, err_o 0.
  - All label-valid bits 0.
- States: IDLE, SCAN, RUN, HALTED.
- IDLE -> SCAN on start_i:
  - PC <= selected base.
  - Base is latched into base_r.
  - All label-valid bits cleared; err_o cleared.
- SCAN: one ROM word per cycle; PC increments by 1.
  - If instruction_i[7:4]==4'hF and instruction_i != 8'hFF: table[instruction_i[3:0]] <= PC and valid[idx] <= 1.
  - Scan ends when instruction_i is HALT_OP or ILLEGAL_OP, or when PC==8'hFF. On the next edge: PC <= base_r, go to RUN.
  - A scan that wraps at 8'hFF without finding a terminator sets err_o but still enters RUN.
  - instr_valid_o is 0 throughout SCAN.
- RUN:
  - instr_o = instruction_i.
  - instr_valid_o = !stall_i.
- Next-PC priority in RUN:
  1. stall_i: hold PC. Branch is ignored while stalled.
  2. branch_i with valid[label]: PC <= table[label]. No bubble.
  3. branch_i with invalid label: err_o <= 1, go to HALTED.
  4. instruction_i == HALT_OP: go to HALTED. Halt is presented with valid=1 for exactly one cycle.
  5. Otherwise PC <= PC+1, wrapping 8'hFF -> 8'h00.
- ILLEGAL_OP fetched in RUN: err_o <= 1, go to HALTED.
- Label markers fetched in RUN are forwarded as valid instructions; decode treats them as nop.
- HALTED:
  - halted_o = 1; PC holds; instr_valid_o = 0.
  - start_i re-enters SCAN with a fresh table.
- start_i is ignored in SCAN and RUN.
- Reset asserted mid-operation aborts immediately to the reset values. The table contents are don't-care; only the valid bits must clear.
- busy_o = (state==SCAN || state==RUN).

Optional Feature:
- Macro: FETCH_DUP_LABEL_CHECK_EN.
- Defined: during SCAN, a marker whose index is already valid sets err_o. The first address is kept, the scan continues, and RUN still follows.
- Undefined: the last marker wins silently; err_o is unaffected by duplicates.

Test Plan:
- Reset mid-SCAN with prog_sel=1, PC=8'h50 -> same cycle: address_o=0, busy_o=0, err_o=0. A later start gives a fresh scan.
- inst_rom, start_i with prog_sel=1 -> SCAN walks 8'h40..8'h8A and stops on 8'hE0. Table: label0=8'h4B, label1=8'h52, label2=8'h5F, label6=8'h7F. RUN then begins at 8'h40 with instr_o=8'hC0, valid=1.
- inst_rom prog 0, RUN at PC 8'h34 (jmp label0) with branch_i=1, label=0 -> next address_o=8'h0B, no invalid cycle.
- stall_i=1 for 3 cycles while branch_i=1 -> PC holds and instr_valid_o=0. The branch is taken on the first unstalled cycle.
- Branch to a label never marked (label 9) -> err_o=1, halted_o=1, PC frozen. start_i clears err_o and restarts the scan.
- Bench ROM with two 8'hF3 markers at 8'h05 and 8'h09 -> with FETCH_DUP_LABEL_CHECK_EN: err_o=1, label3=8'h05. Without it: err_o=0, label3=8'h09.
